// File: rtl/crg_chip_jtag_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crg_jtag_pkg
// Description : Shared TAP definitions: controller state encoding, instruction
//               opcodes and the IR capture pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package crg_jtag_pkg;

    // IEEE 1149.1 controller states using the customary 4-bit encoding
    typedef enum logic [3:0] {
        ST_EX2_DR = 4'h0,
        ST_EX1_DR = 4'h1,
        ST_SH_DR  = 4'h2,
        ST_PAU_DR = 4'h3,
        ST_SEL_IR = 4'h4,
        ST_UPD_DR = 4'h5,
        ST_CAP_DR = 4'h6,
        ST_SEL_DR = 4'h7,
        ST_EX2_IR = 4'h8,
        ST_EX1_IR = 4'h9,
        ST_SH_IR  = 4'hA,
        ST_PAU_IR = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPD_IR = 4'hD,
        ST_CAP_IR = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_e;

    // Low opcodes; zero-extended to the IR width. BYPASS is all-ones.
    localparam int c_op_extest = 0;
    localparam int c_op_sample = 1;
    localparam int c_op_idcode = 2;

    // Fixed pattern loaded into the IR shift register in CAP_IR
    localparam logic [1:0] c_ir_capture = 2'b01;

    // True in either shift state
    function automatic logic is_shift_state(input tap_state_e s);
        return (s == ST_SH_DR) || (s == ST_SH_IR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crg_chip_jtag_tap_if.sv
`default_nettype none
// ============================================================================
// Module      : crg_chip_jtag_tap_if
// Description : Serial JTAG pin bundle (tms/tdi in, tdo/tdo_en out).
// Revision    : 1.0 - initial release
// ============================================================================
interface crg_chip_jtag_tap_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    // Test equipment side drives tms/tdi
    modport master (output tms, output tdi, input tdo, input tdo_en);
    // TAP side receives tms/tdi and drives tdo
    modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface
`default_nettype wire

// File: rtl/crg_chip_jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : crg_jtag_tap_fsm
// Description : IEEE 1149.1 TAP controller with decoded capture/shift/update
//               strobes and an "entering TLR" strobe for synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module crg_jtag_tap_fsm
    import crg_jtag_pkg::*;
(
    input  wire logic tck,
    input  wire logic trst,
    input  wire logic tms,
    output tap_state_e o_state,
    output logic      o_tlr_next,
    output logic      o_cap_dr,
    output logic      o_sh_dr,
    output logic      o_upd_dr,
    output logic      o_cap_ir,
    output logic      o_sh_ir,
    output logic      o_upd_ir
);

    tap_state_e r_state;
    tap_state_e w_next;

    // State register; trst forces TLR immediately
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Standard tms-driven transitions
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:    w_next = tms ? ST_TLR    : ST_RTI;
            ST_RTI:    w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_next = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_next = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_next = tms ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: w_next = tms ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: w_next = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_next = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: w_next = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_next = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_next = tms ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: w_next = tms ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: w_next = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_next = tms ? ST_SEL_DR : ST_RTI;
            default:   w_next = ST_TLR;
        endcase
    end

    assign o_state    = r_state;
    // Registers reset on the edge that lands in TLR, so they are clean in TLR
    assign o_tlr_next = (w_next == ST_TLR);
    assign o_cap_dr   = (r_state == ST_CAP_DR);
    assign o_sh_dr    = (r_state == ST_SH_DR);
    assign o_upd_dr   = (r_state == ST_UPD_DR);
    assign o_cap_ir   = (r_state == ST_CAP_IR);
    assign o_sh_ir    = (r_state == ST_SH_IR);
    assign o_upd_ir   = (r_state == ST_UPD_IR);

endmodule
`default_nettype wire

// File: rtl/crg_chip_jtag_tap.sv
`default_nettype none
// ============================================================================
// Module      : crg_chip_jtag_tap
// Description : JTAG TAP with IR, BYPASS, optional IDCODE and boundary-scan
//               data registers, plus registered tdo/tdo_en.
//               Optional IDCODE register/instruction: define CRG_JTAG_IDCODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module crg_chip_jtag_tap
    import crg_jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          BSR_LEN    = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0C4B
) (
    input  wire logic               tck,
    input  wire logic               trst,
    crg_chip_jtag_tap_if.slave      jtag,
    input  wire logic [BSR_LEN-1:0] bsr_pi,
    output logic      [BSR_LEN-1:0] bsr_po,
    output logic                    extest_mode
);

    localparam logic [IR_W-1:0] c_ir_bypass = {IR_W{1'b1}};
    localparam logic [IR_W-1:0] c_ir_cap    = IR_W'(c_ir_capture);
    localparam logic [31:0]     c_idcode    = IDCODE_VAL | 32'h1;
`ifdef CRG_JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] c_ir_reset  = IR_W'(c_op_idcode);
`else
    localparam logic [IR_W-1:0] c_ir_reset  = c_ir_bypass;
`endif

    tap_state_e w_state;
    logic       w_tlr;
    logic       w_cap_dr;
    logic       w_sh_dr;
    logic       w_upd_dr;
    logic       w_cap_ir;
    logic       w_sh_ir;
    logic       w_upd_ir;

    logic [IR_W-1:0]    r_ir;
    logic [IR_W-1:0]    r_ir_sr;
    logic               r_bypass;
    logic [BSR_LEN-1:0] r_bsr_sr;
    logic [BSR_LEN-1:0] r_bsr_po;
    logic [BSR_LEN-1:0] w_bsr_shift;
    logic               r_tdo;
    logic               r_tdo_en;
    logic               w_is_extest;
    logic               w_is_sample;
    logic               w_sel_bsr;
    logic               w_sel_bypass;
    logic               w_dr_lsb;

    crg_jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (jtag.tms),
        .o_state    (w_state),
        .o_tlr_next (w_tlr),
        .o_cap_dr   (w_cap_dr),
        .o_sh_dr    (w_sh_dr),
        .o_upd_dr   (w_upd_dr),
        .o_cap_ir   (w_cap_ir),
        .o_sh_ir    (w_sh_ir),
        .o_upd_ir   (w_upd_ir)
    );

    // Instruction decode; any opcode not listed falls through to BYPASS
    assign w_is_extest = (r_ir == IR_W'(c_op_extest));
    assign w_is_sample = (r_ir == IR_W'(c_op_sample));
    assign w_sel_bsr   = w_is_extest | w_is_sample;

`ifdef CRG_JTAG_IDCODE_EN
    logic        w_is_idcode;
    logic [31:0] r_idcode;

    assign w_is_idcode  = (r_ir == IR_W'(c_op_idcode));
    assign w_sel_bypass = ~w_sel_bsr & ~w_is_idcode;

    // IDCODE register: loads the device ID in CAP_DR, shifts in SH_DR
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_idcode <= '0;
        end else if (w_tlr) begin
            r_idcode <= '0;
        end else if (w_cap_dr && w_is_idcode) begin
            r_idcode <= c_idcode;
        end else if (w_sh_dr && w_is_idcode) begin
            r_idcode <= {jtag.tdi, r_idcode[31:1]};
        end
    end
`else
    logic w_unused_idcode;

    assign w_unused_idcode = ^c_idcode;
    assign w_sel_bypass    = ~w_sel_bsr;
`endif

    // Boundary shift: tdi enters the MSB; a 1-cell chain is just tdi
    generate
        if (BSR_LEN == 1) begin : g_bsr_one
            assign w_bsr_shift = jtag.tdi;
        end else begin : g_bsr_multi
            assign w_bsr_shift = {jtag.tdi, r_bsr_sr[BSR_LEN-1:1]};
        end
    endgenerate

    // Instruction path: capture pattern, LSB-first shift, update in UPD_IR
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_ir    <= c_ir_reset;
            r_ir_sr <= '0;
        end else if (w_tlr) begin
            r_ir    <= c_ir_reset;
            r_ir_sr <= '0;
        end else begin
            if (w_cap_ir) begin
                r_ir_sr <= c_ir_cap;
            end else if (w_sh_ir) begin
                r_ir_sr <= {jtag.tdi, r_ir_sr[IR_W-1:1]};
            end
            if (w_upd_ir) begin
                r_ir <= r_ir_sr;
            end
        end
    end

    // BYPASS and boundary shift registers; only the selected one moves
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_bypass <= 1'b0;
            r_bsr_sr <= '0;
        end else if (w_tlr) begin
            r_bypass <= 1'b0;
            r_bsr_sr <= '0;
        end else if (w_cap_dr) begin
            r_bypass <= 1'b0;
            if (w_sel_bsr) begin
                r_bsr_sr <= bsr_pi;
            end
        end else if (w_sh_dr) begin
            if (w_sel_bsr) begin
                r_bsr_sr <= w_bsr_shift;
            end else if (w_sel_bypass) begin
                r_bypass <= jtag.tdi;
            end
        end
    end

    // Pin update register; only trst clears it, TLR via tms leaves it alone
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_bsr_po <= '0;
        end else if (w_upd_dr && w_sel_bsr) begin
            r_bsr_po <= r_bsr_sr;
        end
    end

    // LSB of whichever data register the active instruction selects
    always_comb begin
        w_dr_lsb = r_bypass;
        if (w_sel_bsr) begin
            w_dr_lsb = r_bsr_sr[0];
        end
`ifdef CRG_JTAG_IDCODE_EN
        if (w_is_idcode) begin
            w_dr_lsb = r_idcode[0];
        end
`endif
    end

    // Registered serial output and pad enable, valid one edge after entry
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_sh_ir ? r_ir_sr[0] : (w_sh_dr ? w_dr_lsb : 1'b0);
            r_tdo_en <= is_shift_state(w_state);
        end
    end

    assign jtag.tdo    = r_tdo;
    assign jtag.tdo_en = r_tdo_en;
    assign bsr_po      = r_bsr_po;
    assign extest_mode = w_is_extest;

endmodule
`default_nettype wire

// File: doc/crg_chip_jtag_tap.md
CRG_CHIP_JTAG_TAP -- requirements
Module: crg_chip_jtag_tap

Interface
REQ-001 SHALL have parameter IR_W, default 4: instruction register width, minimum 2.
REQ-002 SHALL have parameter BSR_LEN, default 8: number of boundary-scan cells, minimum 1.
REQ-003 SHALL have parameter IDCODE_VAL, default 32'h1000_0C4B: device ID; bit 0 is forced to 1 regardless of the value given.
REQ-004 SHALL have port tck, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port trst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port tms, input, 1: test mode select, sampled on rising tck.
REQ-007 SHALL have port tdi, input, 1: serial data in, sampled on rising tck.
REQ-008 SHALL have port tdo, output, 1: serial data out.
REQ-009 SHALL have port tdo_en, output, 1: output enable for the tdo pad.
REQ-010 SHALL have port bsr_pi, input, BSR_LEN: parallel pin values captured by the boundary register.
REQ-011 SHALL have port bsr_po, output, BSR_LEN: update-register outputs driven to the pins.
REQ-012 SHALL have port extest_mode, output, 1: high while the active instruction is EXTEST.

Function
REQ-013 TAP controller SHALL implement the 16 IEEE 1149.1 states (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, and the IR equivalents), with the standard tms-driven transitions.
REQ-014 From any state, five consecutive rising tck edges with tms=1 SHALL reach TLR.
REQ-015 Opcodes for IR_W=4 SHALL be: EXTEST 0000, SAMPLE/PRELOAD 0001, IDCODE 0010, BYPASS all-ones. For other IR_W, zero-extend the low opcodes; BYPASS is all-ones.
REQ-016 Any undefined opcode SHALL select BYPASS.
REQ-017 CAP_IR SHALL load the IR shift register with {0...,2'b01}.
REQ-018 SH_IR and SH_DR SHALL shift LSB-first: tdi enters the MSB and tdo is the LSB.
REQ-019 The active IR SHALL load from the IR shift register in UPD_IR only.
REQ-020 BYPASS SHALL use a 1-bit register cleared in CAP_DR, giving tdi-to-tdo latency of exactly 1 tck.
REQ-021 IDCODE SHALL use a 32-bit register loaded with IDCODE_VAL|1 in CAP_DR.
REQ-022 SAMPLE and EXTEST SHALL load the boundary shift register from bsr_pi in CAP_DR.
REQ-023 In UPD_DR, SAMPLE and EXTEST SHALL copy the boundary shift register to bsr_po.
REQ-024 bsr_po SHALL hold its value in all other states and under all other instructions.
REQ-025 tdo SHALL be registered on rising tck from the LSB of the selected register while in SH_IR/SH_DR, and 0 otherwise.
REQ-026 tdo_en SHALL be registered: 1 in the cycle after entry to SH_IR/SH_DR, held until the cycle after exit.
REQ-027 PAU_xx states SHALL freeze all shift registers.
REQ-028 Simultaneous trst and tck edge: reset SHALL win.

Reset
REQ-029 trst SHALL asynchronously force state=TLR, active IR=IDCODE (BYPASS when the Configuration macro is absent), shift registers=0, bsr_po=0, tdo=0, tdo_en=0, extest_mode=0.
REQ-030 Entering TLR via tms SHALL have the same effect as trst, except bsr_po, which holds its value.
REQ-031 trst asserted mid-shift SHALL abort the shift; no update occurs.

Configuration
REQ-032 Macro CRG_JTAG_IDCODE_EN defined: the IDCODE register and instruction SHALL exist, and reset IR=IDCODE.
REQ-033 Macro CRG_JTAG_IDCODE_EN undefined: no IDCODE register SHALL exist; opcode 0010 SHALL act as BYPASS; reset IR=BYPASS.

Structure
REQ-034 Package crg_jtag_pkg SHALL hold the TAP state enum (4-bit encoding), the opcode constants and the IR capture pattern.
REQ-035 The TAP FSM SHALL be a sub-module crg_jtag_tap_fsm (inputs tck, trst, tms; outputs state and decoded capture/shift/update strobes).
REQ-036 The data registers and muxing SHALL reside in crg_chip_jtag_tap.

Verification
REQ-037 Scenario: trst pulse, then tms 0,1,0,0 to SH_DR, shift 32 -> tdo yields 32'h1000_0C4B LSB-first, tdo_en=1 during the shift.
REQ-038 Scenario: load IR=1111, shift pattern 1,0,1,1 in SH_DR -> tdo shows 0,1,0,1,1 (one-cycle delay, leading 0).
REQ-039 Scenario: SH_IR after reset with IR_W=4 -> first 4 tdo bits 1,0,0,0.
REQ-040 Scenario: IR=0001, bsr_pi=8'hA5, capture and shift in 8'h3C, UPD_DR -> tdo yields A5 bits, bsr_po=8'h3C; then IR=0000 -> extest_mode=1.
REQ-041 Scenario: from SH_DR and from PAU_IR, five tms=1 clocks -> state TLR, IR=IDCODE, bsr_po unchanged.
REQ-042 Scenario: trst asserted mid-SH_DR under EXTEST -> immediate TLR, bsr_po=0, tdo_en=0, no UPD_DR effect.
